// File: rtl/lut4_cfg_loader.sv
// Reconfigurable 4-input LUT with double-buffered truth table.
// A captured table is shifted MSB-first into a shadow register, then committed in one edge.
module lut4_cfg_loader #(
    parameter logic [15:0] INIT = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CFG_VALID,
    input  logic [15:0] CFG_DATA,
    output logic        CFG_READY,
    input  logic        I0,
    input  logic        I1,
    input  logic        I2,
    input  logic        I3,
    output logic        LO,
    output logic        CDO,
    output logic        BUSY,
    output logic        DONE
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

    state_t      r_state;
    logic [15:0] r_active;
    logic [15:0] r_shadow;
    logic [15:0] r_buf;
    logic [3:0]  r_cnt;
    logic        r_done;
    logic [3:0]  w_addr;

    assign w_addr    = {I3, I2, I1, I0};
    assign LO        = r_active[w_addr];
    assign CDO       = r_shadow[15];
    assign CFG_READY = (r_state == S_IDLE) && !RST;
    assign BUSY      = (r_state == S_SHIFT) || (r_state == S_COMMIT);
    assign DONE      = r_done;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_buf    <= 16'h0000;
            r_shadow <= INIT;
            r_active <= INIT;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (CFG_VALID) begin
                        r_buf   <= CFG_DATA;
                        r_cnt   <= 4'd0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Shadow also feeds CDO, so the old contents stream out as the new ones enter.
                    r_shadow <= {r_shadow[14:0], r_buf[15]};
                    r_buf    <= {r_buf[14:0], 1'b0};
                    r_cnt    <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_state <= S_COMMIT;
                        r_done  <= 1'b1;
                    end
                end
                S_COMMIT: begin
                    r_active <= r_shadow;
                    r_done   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end
endmodule
